// File: rtl/adc_frame_sequencer.sv
// Frame sequencer for the dual serial ADC pair: issues the conversion strobe,
// deserialises the four 12-bit channels and hands each frame over valid/ready.
module adc_frame_sequencer #(
  parameter int unsigned CYCLES_PER_SAMPLE = 16,
  parameter int unsigned DATA_OFFSET       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        single,
  input  logic        abort,
  output logic        busy,
  output logic        ad_cs,
  input  logic [1:0]  ad_sdata_a,
  input  logic [1:0]  ad_sdata_b,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [11:0] vcap,
  output logic [11:0] icap,
  output logic [11:0] vout,
  output logic [11:0] iout,
  output logic [15:0] sample_count,
  output logic        overrun,
  input  logic        overrun_clr
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [4:0] CNT_LAST  = 5'(CYCLES_PER_SAMPLE - 1);
  localparam logic [4:0] CAP_FIRST = 5'(DATA_OFFSET + 1);
  localparam logic [4:0] CAP_LAST  = 5'(DATA_OFFSET + 12);
  localparam logic [4:0] CNT_DONE  = 5'(DATA_OFFSET + 13);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ad_cs_q, ad_cs_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic [15:0] count_q, count_d;
  logic [11:0] sr_vcap_q, sr_vcap_d, sr_icap_q, sr_icap_d;
  logic [11:0] sr_vout_q, sr_vout_d, sr_iout_q, sr_iout_d;
  logic [11:0] vcap_q, vcap_d, icap_q, icap_d;
  logic [11:0] vout_q, vout_d, iout_q, iout_d;

  logic xfer;
  logic capture;
  logic complete;

  assign xfer     = valid_q && sample_ready;
  assign capture  = (state_q == CONV) && (cnt_q >= CAP_FIRST) && (cnt_q <= CAP_LAST);
  // An abort on the completion edge still kills the frame.
  assign complete = (state_q == CONV) && (cnt_q == CNT_DONE) && !abort;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    count_d   = count_q;
    sr_vcap_d = sr_vcap_q;
    sr_icap_d = sr_icap_q;
    sr_vout_d = sr_vout_q;
    sr_iout_d = sr_iout_q;
    vcap_d    = vcap_q;
    icap_d    = icap_q;
    vout_d    = vout_q;
    iout_d    = iout_q;

    unique case (state_q)
      IDLE: begin
        if (!abort && (enable || single)) begin
          state_d = CONV;
          cnt_d   = '0;
        end
      end
      CONV: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!enable) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    endcase

    if (capture) begin
      sr_vcap_d = {sr_vcap_q[10:0], ad_sdata_b[1]};
      sr_icap_d = {sr_icap_q[10:0], ad_sdata_b[0]};
      sr_vout_d = {sr_vout_q[10:0], ad_sdata_a[1]};
      sr_iout_d = {sr_iout_q[10:0], ad_sdata_a[0]};
    end

    if (complete) begin
      vcap_d  = sr_vcap_q;
      icap_d  = sr_icap_q;
      vout_d  = sr_vout_q;
      iout_d  = sr_iout_q;
      valid_d = 1'b1;
      count_d = count_q + 16'd1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    overrun_d = (overrun_q && !overrun_clr) || (complete && valid_q && !sample_ready);
    ad_cs_d   = (state_d == CONV) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ad_cs_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
      sr_vcap_q <= '0;
      sr_icap_q <= '0;
      sr_vout_q <= '0;
      sr_iout_q <= '0;
      vcap_q    <= '0;
      icap_q    <= '0;
      vout_q    <= '0;
      iout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ad_cs_q   <= ad_cs_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
      sr_vcap_q <= sr_vcap_d;
      sr_icap_q <= sr_icap_d;
      sr_vout_q <= sr_vout_d;
      sr_iout_q <= sr_iout_d;
      vcap_q    <= vcap_d;
      icap_q    <= icap_d;
      vout_q    <= vout_d;
      iout_q    <= iout_d;
    end
  end

  assign busy         = (state_q == CONV);
  assign ad_cs        = ad_cs_q;
  assign sample_valid = valid_q;
  assign vcap         = vcap_q;
  assign icap         = icap_q;
  assign vout         = vout_q;
  assign iout         = iout_q;
  assign sample_count = count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed bench for adc_frame_sequencer: default instance plus a
// DATA_OFFSET=2 / CYCLES_PER_SAMPLE=20 instance, each fed by a serial ADC model.
module tb_adc_frame_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, single = 1'b0, abort = 1'b0;
  logic sample_ready = 1'b0, overrun_clr = 1'b0;

  logic        busy, ad_cs, sample_valid, overrun;
  logic [1:0]  sdata_a = '0, sdata_b = '0;
  logic [11:0] vcap, icap, vout, iout;
  logic [15:0] sample_count;

  logic        busy2, ad_cs2, valid2, overrun2;
  logic [1:0]  sdata_a2 = '0, sdata_b2 = '0;
  logic [11:0] vcap2, icap2, vout2, iout2;
  logic [15:0] count2;

  int n_checks = 0;
  int n_fail   = 0;

  // ADC model state: next frame words (nx), words of frame in flight (cur)
  logic [11:0] nx_vc = '0, nx_ic = '0, nx_vo = '0, nx_io = '0;
  logic [11:0] cur_vc = '0, cur_ic = '0, cur_vo = '0, cur_io = '0;
  logic [11:0] nx2_vc = '0, nx2_ic = '0, nx2_vo = '0, nx2_io = '0;
  logic [11:0] cur2_vc = '0, cur2_ic = '0, cur2_vo = '0, cur2_io = '0;
  bit ramp = 1'b0;
  int ph1 = 100, ph2 = 100;

  always #5 clk = ~clk;

  adc_frame_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .single(single), .abort(abort),
    .busy(busy), .ad_cs(ad_cs), .ad_sdata_a(sdata_a), .ad_sdata_b(sdata_b),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .vcap(vcap), .icap(icap), .vout(vout), .iout(iout),
    .sample_count(sample_count), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  adc_frame_sequencer #(.CYCLES_PER_SAMPLE(20), .DATA_OFFSET(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .single(single), .abort(abort),
    .busy(busy2), .ad_cs(ad_cs2), .ad_sdata_a(sdata_a2), .ad_sdata_b(sdata_b2),
    .sample_valid(valid2), .sample_ready(sample_ready),
    .vcap(vcap2), .icap(icap2), .vout(vout2), .iout(iout2),
    .sample_count(count2), .overrun(overrun2), .overrun_clr(overrun_clr)
  );

  // Bit 11-k is presented during frame cycle off+1+k, MSB first.
  function automatic logic bit_at(input logic [11:0] w, input int ph, input int off);
    int k;
    k = ph - off - 1;
    if (k >= 0 && k <= 11) return w[11-k];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (ad_cs) begin
      ph1 = 0;
      cur_vc = nx_vc; cur_ic = nx_ic; cur_vo = nx_vo; cur_io = nx_io;
      if (ramp) begin
        nx_vc = nx_vc + 12'd1; nx_ic = nx_ic + 12'd1;
        nx_vo = nx_vo + 12'd1; nx_io = nx_io + 12'd1;
      end
    end else if (ph1 < 100) ph1++;
    sdata_a = {bit_at(cur_vo, ph1, 1), bit_at(cur_io, ph1, 1)};
    sdata_b = {bit_at(cur_vc, ph1, 1), bit_at(cur_ic, ph1, 1)};
  end

  always @(negedge clk) begin
    if (ad_cs2) begin
      ph2 = 0;
      cur2_vc = nx2_vc; cur2_ic = nx2_ic; cur2_vo = nx2_vo; cur2_io = nx2_io;
    end else if (ph2 < 100) ph2++;
    sdata_a2 = {bit_at(cur2_vo, ph2, 2), bit_at(cur2_io, ph2, 2)};
    sdata_b2 = {bit_at(cur2_vc, ph2, 2), bit_at(cur2_ic, ph2, 2)};
  end

  task automatic apply_reset;
    reset = 1'b1; enable = 1'b0; single = 1'b0; abort = 1'b0;
    sample_ready = 1'b0; overrun_clr = 1'b0; ramp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Leaves the bench at the negedge of the cycle the strobe is expected in.
  task automatic pulse_single;
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    n_checks++;
    if ({busy, ad_cs, sample_valid, overrun} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, ad_cs, sample_valid, overrun});
    end
    n_checks++;
    if ({vcap, icap, vout, iout, sample_count} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {vcap, icap, vout, iout, sample_count});
    end
    pulse_single;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({busy, ad_cs, sample_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_midframe: got %b expected 000", {busy, ad_cs, sample_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({busy, ad_cs, sample_count} !== 18'h0) begin
      n_fail++; $display("FAIL reset_no_cs: got %h expected 0", {busy, ad_cs, sample_count});
    end
  endtask

  task automatic test_single_shot;
    apply_reset;
    nx_vc = 12'h320; nx_ic = 12'hF00; nx_vo = 12'h123; nx_io = 12'hABC;
    pulse_single;
    n_checks++;
    if ({ad_cs, busy} !== 2'b11) begin
      n_fail++; $display("FAIL single_cs: got %b expected 11", {ad_cs, busy});
    end
    // Completion edge ends cycle DATA_OFFSET+13 = 14, so valid shows from cycle 15.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ad_cs, sample_valid, busy} !== {1'b0, i >= 15, i < 16}) begin
        n_fail++;
        $display("FAIL single_timing cyc %0d: got cs/valid/busy %b expected %b",
                 i, {ad_cs, sample_valid, busy}, {1'b0, i >= 15, i < 16});
      end
    end
    n_checks++;
    if ({vcap, icap, vout, iout} !== 48'h320_F00_123_ABC) begin
      n_fail++; $display("FAIL single_data: got %h expected 320f00123abc", {vcap, icap, vout, iout});
    end
    n_checks++;
    if (sample_count !== 16'd1) begin
      n_fail++; $display("FAIL single_count: got %0d expected 1", sample_count);
    end
  endtask

  task automatic test_continuous;
    int n_cs, n_val, last, drop;
    apply_reset;
    nx_vc = 12'h100; nx_ic = 12'h200; nx_vo = 12'h300; nx_io = 12'h400;
    ramp = 1'b1; sample_ready = 1'b1; enable = 1'b1;
    n_cs = 0; n_val = 0; last = 0; drop = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (ad_cs) begin
        n_cs++;
        if (n_cs > 1) begin
          n_checks++;
          if (cyc - last !== 16) begin
            n_fail++; $display("FAIL cont_cs_period: got %0d expected 16", cyc - last);
          end
        end
        last = cyc;
        if (n_cs == 10) drop = cyc + 5;
      end
      if (sample_valid) begin
        n_checks++;
        if ({vcap, icap, vout, iout} !== {12'(256 + n_val), 12'(512 + n_val), 12'(768 + n_val), 12'(1024 + n_val)}) begin
          n_fail++;
          $display("FAIL cont_data frame %0d: got %h expected %h", n_val, {vcap, icap, vout, iout},
                   {12'(256 + n_val), 12'(512 + n_val), 12'(768 + n_val), 12'(1024 + n_val)});
        end
        n_val++;
      end
      if (cyc == drop) enable = 1'b0;
      if (drop > 0 && cyc > drop && !busy) break;
    end
    ramp = 1'b0; enable = 1'b0;
    n_checks++;
    if (n_cs !== 10 || n_val !== 10 || busy !== 1'b0) begin
      n_fail++; $display("FAIL cont_frames: got cs=%0d valid=%0d busy=%b expected 10 10 0", n_cs, n_val, busy);
    end
    n_checks++;
    if (sample_count !== 16'd10) begin
      n_fail++; $display("FAIL cont_count: got %0d expected 10", sample_count);
    end
  endtask

  task automatic test_backpressure;
    int n_cs;
    apply_reset;
    nx_vc = 12'h500; nx_ic = 12'h600; nx_vo = 12'h700; nx_io = 12'h800;
    ramp = 1'b1; enable = 1'b1; n_cs = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (ad_cs) begin
        n_cs++;
        if (n_cs == 3) enable = 1'b0;
      end
      if (n_cs >= 3 && !busy) break;
    end
    ramp = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({overrun, sample_valid, busy} !== 3'b110) begin
      n_fail++; $display("FAIL bp_flags: got ovr/valid/busy %b expected 110", {overrun, sample_valid, busy});
    end
    n_checks++;
    if ({vcap, icap, vout, iout} !== 48'h502_602_702_802 || sample_count !== 16'd3) begin
      n_fail++; $display("FAIL bp_data: got %h cnt %0d expected 502602702802 cnt 3", {vcap, icap, vout, iout}, sample_count);
    end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    n_checks++;
    if ({sample_valid, overrun} !== 2'b01) begin
      n_fail++; $display("FAIL bp_xfer: got valid/ovr %b expected 01", {sample_valid, overrun});
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL bp_ovr_clr: got %b expected 0", overrun);
    end
  endtask

  task automatic test_same_cycle;
    apply_reset;
    nx_vc = 12'h011; nx_ic = 12'h022; nx_vo = 12'h033; nx_io = 12'h044;
    pulse_single;
    repeat (16) @(negedge clk);
    nx_vc = 12'hA55; nx_ic = 12'h5AA; nx_vo = 12'hC3C; nx_io = 12'h3C3;
    pulse_single;
    n_checks++;
    if ({ad_cs, sample_valid} !== 2'b11) begin
      n_fail++; $display("FAIL sc_start: got cs/valid %b expected 11", {ad_cs, sample_valid});
    end
    repeat (14) @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b1 || {vcap, icap, vout, iout} !== 48'h011_022_033_044) begin
      n_fail++; $display("FAIL sc_hold: got valid %b data %h expected 1 011022033044", sample_valid, {vcap, icap, vout, iout});
    end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    n_checks++;
    if ({sample_valid, overrun} !== 2'b10 || {vcap, icap, vout, iout} !== 48'hA55_5AA_C3C_3C3) begin
      n_fail++; $display("FAIL sc_load: got valid/ovr %b data %h expected 10 a555aac3c3c3", {sample_valid, overrun}, {vcap, icap, vout, iout});
    end
    n_checks++;
    if (sample_count !== 16'd2) begin
      n_fail++; $display("FAIL sc_count: got %0d expected 2", sample_count);
    end
  endtask

  task automatic test_abort;
    int n_cs, n_val;
    apply_reset;
    nx_vc = 12'h111; nx_ic = 12'h222; nx_vo = 12'h333; nx_io = 12'h444;
    pulse_single;
    repeat (16) @(negedge clk);
    nx_vc = 12'h999; nx_ic = 12'h888; nx_vo = 12'h777; nx_io = 12'h666;
    pulse_single;
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, sample_valid} !== 2'b01) begin
      n_fail++; $display("FAIL abort_busy: got busy/valid %b expected 01", {busy, sample_valid});
    end
    n_cs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ad_cs) n_cs++;
    end
    n_checks++;
    if (n_cs !== 0 || {vcap, icap, vout, iout} !== 48'h111_222_333_444 || sample_count !== 16'd1) begin
      n_fail++; $display("FAIL abort_keep: got cs=%0d data %h cnt %0d expected 0 111222333444 1", n_cs, {vcap, icap, vout, iout}, sample_count);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, sample_valid, overrun} !== 3'b010) begin
      n_fail++; $display("FAIL abort_idle: got busy/valid/ovr %b expected 010", {busy, sample_valid, overrun});
    end
    sample_ready = 1'b1;
    @(negedge clk);
    nx_vc = 12'h0AB; nx_ic = 12'h0CD; nx_vo = 12'h0EF; nx_io = 12'h012;
    pulse_single;
    n_cs = ad_cs ? 1 : 0;
    n_val = 0;
    repeat (4) @(negedge clk);
    pulse_single;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ad_cs) n_cs++;
      if (sample_valid) begin
        n_val++;
        n_checks++;
        if ({vcap, icap, vout, iout} !== 48'h0AB_0CD_0EF_012) begin
          n_fail++; $display("FAIL busy_single_data: got %h expected 0ab0cd0ef012", {vcap, icap, vout, iout});
        end
      end
    end
    sample_ready = 1'b0;
    n_checks++;
    if (n_cs !== 1 || n_val !== 1 || sample_count !== 16'd2) begin
      n_fail++; $display("FAIL busy_single: got cs=%0d valid=%0d cnt=%0d expected 1 1 2", n_cs, n_val, sample_count);
    end
  endtask

  task automatic test_param;
    apply_reset;
    nx2_vc = 12'h5A5; nx2_ic = 12'h0F0; nx2_vo = 12'hF0F; nx2_io = 12'h381;
    pulse_single;
    n_checks++;
    if ({ad_cs2, busy2} !== 2'b11) begin
      n_fail++; $display("FAIL param_cs: got %b expected 11", {ad_cs2, busy2});
    end
    // DATA_OFFSET=2: completion edge ends cycle 15, valid from cycle 16; frame is 20 cycles.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ad_cs2, valid2, busy2} !== {1'b0, i >= 16, i < 20}) begin
        n_fail++;
        $display("FAIL param_timing cyc %0d: got cs/valid/busy %b expected %b",
                 i, {ad_cs2, valid2, busy2}, {1'b0, i >= 16, i < 20});
      end
    end
    n_checks++;
    if ({vcap2, icap2, vout2, iout2} !== 48'h5A5_0F0_F0F_381 || count2 !== 16'd1) begin
      n_fail++; $display("FAIL param_data: got %h cnt %0d expected 5a50f0f0f381 1", {vcap2, icap2, vout2, iout2}, count2);
    end
  endtask

  task automatic test_wrap;
    apply_reset;
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    sample_ready = 1'b1;
    pulse_single;
    repeat (16) @(negedge clk);
    n_checks++;
    if (sample_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_count: got %h expected 0000", sample_count);
    end
    pulse_single;
    repeat (16) @(negedge clk);
    sample_ready = 1'b0;
    n_checks++;
    if (sample_count !== 16'h0001) begin
      n_fail++; $display("FAIL wrap_next: got %h expected 0001", sample_count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_single_shot;
    test_continuous;
    test_backpressure;
    test_same_cycle;
    test_abort;
    test_param;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Owns the dual serial A/D converter pair on the blaster board: generates the conversion strobe, deserialises the four 12-bit channels (vcap, icap, vout, iout), and presents each completed frame on a valid/ready interface. Supports continuous sampling for the fire loop and single-shot sampling for pre-fire self-test. The launch state machine and PWM current loop consume its frames instead of running ADC timing themselves.

Parameters:
CYCLES_PER_SAMPLE, 16, frame period in clk cycles (16 gives 3 MHz at 48 MHz); legal range DATA_OFFSET+14 to 31.
DATA_OFFSET, 1, cycles between the ad_cs pulse and the cycle in which the first sampled MSB is valid; legal range 0 to 3.

Ports:
clk  in  1  system clock (48 MHz)
reset  in  1  synchronous, active-high reset
enable  in  1  level; continuous back-to-back frames while high
single  in  1  one-cycle pulse; request exactly one frame
abort  in  1  one-cycle pulse; kill the in-flight frame immediately
busy  out  1  high while a frame is in progress
ad_cs  out  1  conversion strobe to both ADCs, one cycle high per frame
ad_sdata_a  in  2  serial data, ADC A: [1]=vout, [0]=iout
ad_sdata_b  in  2  serial data, ADC B: [1]=vcap, [0]=icap
sample_valid  out  1  frame data available
sample_ready  in  1  consumer accepts frame
vcap  out  12  F9.2 volts
icap  out  12  F4.8 amps
vout  out  12  F9.2 volts
iout  out  12  F4.8 amps
sample_count  out  16  completed frames since reset, wraps
overrun  out  1  sticky: unaccepted frame was overwritten
overrun_clr  in  1  clears overrun

Behaviour:
- Reset: state IDLE, frame counter 0, busy=0, ad_cs=0, sample_valid=0, vcap/icap/vout/iout=0, sample_count=0, overrun=0, shift registers 0.
- States: IDLE, CONV. Frame counter cnt counts 0..CYCLES_PER_SAMPLE-1 in CONV only.
- IDLE -> CONV (cnt=0) when enable=1, or when single=1. Cycle cnt=0 is the first cycle of CONV; busy=1 throughout CONV.
- ad_cs=1 exactly when state=CONV and cnt=0 (registered output), otherwise 0.
- Bit capture, MSB first: the bit for position 11-k is sampled on the clock edge ending cycle cnt = DATA_OFFSET+1+k, for k=0..11. All four lines are captured on the same edge.
- Frame completion: on the edge ending cnt = DATA_OFFSET+13, the four output registers load from the shift registers, sample_valid goes 1, and sample_count increments, wrapping 0xFFFF->0. Latency from the ad_cs cycle to sample_valid is DATA_OFFSET+13 cycles (14 by default).
- End of frame, on the edge ending cnt=CYCLES_PER_SAMPLE-1:
  - enable=1 -> cnt=0 and remain in CONV (gapless; ad_cs period = CYCLES_PER_SAMPLE).
  - otherwise -> IDLE.
  - A single pulse arriving in IDLE coincident with this edge's IDLE entry is honoured next cycle.
- single while busy: ignored, not queued. enable=1 with single=1: continuous mode, single is redundant.
- enable falling mid-frame: the current frame completes normally, then the block goes to IDLE.
- abort (highest priority): the next state is IDLE and cnt=0. A partial frame does not load the outputs, does not assert valid, and does not increment the count. Already-valid data and the sample_valid flag are untouched. abort in IDLE has no effect; abort and single together give IDLE.
- Handshake: a transfer occurs when sample_valid and sample_ready are both 1. Once set, sample_valid holds until the transfer.
  - Transfer only, no completion -> sample_valid goes 0.
  - Completion and transfer in the same cycle -> new data loads, sample_valid stays 1, no overrun.
  - Completion while sample_valid=1 and sample_ready=0 -> data is overwritten, sample_valid stays 1, overrun is set.
  - Outputs are stable while valid and not transferred, except in the overwrite case.
- overrun: sticky. overrun_clr clears it; a set event in the same cycle wins.
- Reset mid-frame: immediate return to reset values; no ad_cs in the next cycle.

Test Plan:
- Single shot: single pulse in IDLE; ADC model drives vcap=0x320, icap=0x0F00, vout=0x123, iout=0x0ABC -> ad_cs high one cycle, sample_valid 14 cycles later, outputs exact, sample_count=1, busy low after 16 cycles.
- Continuous with ready=1: enable held for 10 frames -> ad_cs every 16 cycles with no gap, 10 valid pulses each with distinct ramp data, sample_count=10; dropping enable mid-frame 10 -> frame 10 completes, then IDLE.
- Backpressure: enable=1, sample_ready=0 for 3 frames -> overrun=1, outputs hold frame 3 data, sample_valid stays 1; then ready=1 for one cycle -> valid drops; overrun_clr -> overrun=0.
- Same-cycle completion and transfer: ready pulsed exactly on the completion edge -> new data loaded, valid stays 1, overrun stays 0.
- Abort: abort at cnt=7 -> busy=0 next cycle, no valid, sample_count unchanged, prior outputs unchanged; single issued while busy -> ignored, exactly one frame seen.
- Parameter and wrap: DATA_OFFSET=2, CYCLES_PER_SAMPLE=20 -> capture shifted one cycle, valid at 15 cycles after ad_cs; preload 0xFFFF frames -> sample_count wraps to 0.
